adder_nbit_pipe: RTL and testbench
==================================

# adder_nbit_pipe

Parametrised N-bit adder/subtractor whose carry chain is split into STAGES registered slices, giving a one-result-per-cycle datapath with a valid/ready handshake on both sides. It is the next generation of the lab's 8-bit ripple adder. It adds configurable width, pipelining, a subtract mode, separate carry and signed-overflow flags, and downstream backpressure. It sits between an operand producer (register file / FSM) and a result consumer, and is built from 1-bit full-adder slices.

## Interface
- WIDTH, 16, operand/result width in bits; WIDTH >= 2.
- STAGES, 4, number of pipeline register stages; STAGES >= 1, WIDTH % STAGES == 0; slice width C = WIDTH/STAGES.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A (unsigned/two's complement).
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0 (add mode only).
- sub  input  1  0 = A+B+carry_in, 1 = A-B (A + ~B + 1, carry_in ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result.
- carry_out  output  1  carry out of bit WIDTH-1 (in sub mode, 1 = no borrow).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Global advance enable en = !out_valid || out_ready. in_ready = en && !rst (combinational).
- Stage k (0..STAGES-1) adds slice bits [k*C +: C] of the skewed operands with the carry registered by stage k-1. Stage 0 uses carry_in, or 1 when sub=1. B is inverted when sub=1.
- Operand slices for later stages, the sub flag and result slices from earlier stages are delayed in shift registers so each transaction's bits stay aligned. The pipeline carries a per-stage valid bit.
- When en=1, every stage register (data, carry, valid) shifts by one. Bubbles (valid=0) propagate and are not collapsed. When en=0, all stage registers hold.
- Stage 0's valid loads in_valid && in_ready.
- The last stage produces sum, carry_out, overflow and out_valid; these are registered outputs.
- Outputs are stable while out_valid=1 && out_ready=0.
- Results emerge strictly in acceptance order, with no loss or duplication.
- sum wraps modulo 2^WIDTH. No saturation.
- STAGES=1 degenerates to a single registered WIDTH-bit adder with the same handshake.

## Timing
- Reset, applied at any edge with rst=1: all stage valid bits, out_valid, sum, carry_out and overflow become 0 after that edge. Data already in flight is discarded.
- in_ready=0 in any cycle where rst=1.
- First accept is possible in the cycle after rst falls.
- Latency: an operand accepted at edge t gives out_valid=1 in the cycle following edge t+STAGES-1 (STAGES cycles), provided no stall occurs.
- Each cycle with en=0 adds exactly one cycle of latency to every in-flight item.
- Throughput: 1 result per cycle while out_ready=1.
- Simultaneous output transfer and input accept in the same cycle is legal, including with a full pipeline.
- in_ready is a function of out_valid/out_ready/rst only, never of in_valid.
- Critical path: one C-bit ripple plus the carry register.

## Test plan
- WIDTH=16, STAGES=4, reset, then 0x00FF+0x0001, cin=0, sub=0 -> out_valid 4 cycles later; sum=0x0100, carry_out=0, overflow=0.
- 0xFFFF+0x0001, cin=0 -> sum=0x0000, carry_out=1, overflow=0 (carry crosses all 4 stages). 0x7FFF+0x0001 -> 0x8000, carry_out=0, overflow=1.
- sub=1, with carry_in=1 driven and ignored: 0x0005-0x0007 -> 0xFFFE, carry_out=0, overflow=0. 0x8000-0x0001 -> 0x7FFF, carry_out=1, overflow=1.
- Stream 8 back-to-back ops; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall. Outputs hold steady; all 8 results arrive in order with correct values; no drops or duplicates.
- Accept 3 ops, then assert rst for 1 cycle -> out_valid=0, sum=0 after that edge; none of the 3 results ever appear. An op accepted after reset completes in 4 cycles.
- WIDTH=8, STAGES=1: 0xFF+0x00, cin=1 -> sum=0x00, carry_out=1, overflow=0, out_valid 1 cycle after accept. Random 1000-op run matches a reference model for both configurations.

Source files
------------

// File: rtl/adder_nbit_pipe.sv
// adder_nbit_pipe: WIDTH-bit add/sub split into STAGES registered carry-chain slices with valid/ready handshake
module adder_nbit_pipe #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int C = WIDTH / STAGES;
  logic en;
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [STAGES-1:0] v_d, v_q, cy_d, cy_q;
  logic ov_d, ov_q;
  assign en = !v_q[STAGES-1] || out_ready;
  assign in_ready = en && !rst;
  // B is inverted once at entry so every later slice sees the effective operand
  always_comb begin
    logic [WIDTH-1:0] ai, bi, si;
    logic ci, cm;
    ai = '0;
    bi = '0;
    si = '0;
    ci = 1'b0;
    cm = 1'b0;
    a_d = '{default: '0};
    b_d = '{default: '0};
    sum_d = '{default: '0};
    v_d = '0;
    cy_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      ai = (k == 0) ? a : a_q[(k == 0) ? 0 : k - 1];
      bi = (k == 0) ? (b ^ {WIDTH{sub}}) : b_q[(k == 0) ? 0 : k - 1];
      si = (k == 0) ? '0 : sum_q[(k == 0) ? 0 : k - 1];
      ci = (k == 0) ? (sub | carry_in) : cy_q[(k == 0) ? 0 : k - 1];
      for (int i = k * C; i < (k + 1) * C; i++) begin
        cm = ci;
        si[i] = ai[i] ^ bi[i] ^ ci;
        ci = (ai[i] & bi[i]) | (ci & (ai[i] ^ bi[i]));
      end
      a_d[k] = ai;
      b_d[k] = bi;
      sum_d[k] = si;
      cy_d[k] = ci;
      v_d[k] = (k == 0) ? (in_valid && in_ready) : v_q[(k == 0) ? 0 : k - 1];
    end
    ov_d = cm ^ cy_d[STAGES-1];
  end
  always_ff @(posedge clk)
    if (rst) begin
      v_q <= '0;
      cy_q <= '0;
      ov_q <= 1'b0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      sum_q <= '{default: '0};
    end else if (en) begin
      v_q <= v_d;
      cy_q <= cy_d;
      ov_q <= ov_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
    end
  assign out_valid = v_q[STAGES-1];
  assign sum = sum_q[STAGES-1];
  assign carry_out = cy_q[STAGES-1];
  assign overflow = ov_q;
endmodule

// File: tb/tb_adder_nbit_pipe.sv
// tb_adder_nbit_pipe: directed and randomized checks of the 16/4 and 8/1 configurations against an arithmetic model
module tb_adder_nbit_pipe;
  logic clk = 0, rst = 1, sel = 0, iv = 0, ordy = 1, cin = 0, sub = 0;
  logic [15:0] a = '0, b = '0;
  logic iv16, ir16, ov16, co16, of16, iv8, ir8, ov8, co8, of8;
  logic [15:0] s16;
  logic [7:0] s8;
  logic ir, ov, co, of;
  logic [15:0] s;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  adder_nbit_pipe #(.WIDTH(16), .STAGES(4)) u16 (.clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a), .b(b), .carry_in(cin), .sub(sub), .out_valid(ov16), .out_ready(ordy), .sum(s16),
    .carry_out(co16), .overflow(of16));
  adder_nbit_pipe #(.WIDTH(8), .STAGES(1)) u8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .carry_in(cin), .sub(sub), .out_valid(ov8), .out_ready(ordy), .sum(s8),
    .carry_out(co8), .overflow(of8));
  assign iv16 = iv && !sel;
  assign iv8 = iv && sel;
  assign ir = sel ? ir8 : ir16;
  assign ov = sel ? ov8 : ov16;
  assign co = sel ? co8 : co16;
  assign of = sel ? of8 : of16;
  assign s = sel ? {8'h00, s8} : s16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {logic [15:0] s; logic co; logic of; int cyc; int stl;} exp_t;
  exp_t q[$];

  // Reference: plain unsigned/signed integer arithmetic over w bits
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic m, input int w);
    exp_t e;
    longint md = longint'(1) << w;
    longint ux = longint'(x) % md, uy = longint'(y) % md;
    longint sx = (ux >= md / 2) ? ux - md : ux;
    longint sy = (uy >= md / 2) ? uy - md : uy;
    longint r = m ? ux - uy : ux + uy + longint'(c);
    longint sr = m ? sx - sy : sx + sy + longint'(c);
    e.s = 16'(((r % md) + md) % md);
    e.co = m ? (ux >= uy) : (r >= md);
    e.of = (sr >= md / 2) || (sr < -(md / 2));
    e.cyc = 0;
    e.stl = 0;
    return e;
  endfunction

  int cyc = 0, stl = 0;
  logic hold = 0, pco = 0, pof = 0;
  logic [15:0] ps = '0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    check("in_ready", 32'(ir), 32'(!rst && (!ov || ordy)));
    if (hold) begin
      check("hold_valid", 32'(ov), 32'd1);
      check("hold_sum", 32'(s), 32'(ps));
      check("hold_flags", 32'({co, of}), 32'({pco, pof}));
    end
    if (!rst && ov && ordy) begin
      if (q.size() == 0) check("spurious_result", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("sum", 32'(s), 32'(e.s));
        check("carry_out", 32'(co), 32'(e.co));
        check("overflow", 32'(of), 32'(e.of));
        check("latency", 32'(cyc - e.cyc), 32'((sel ? 1 : 4) + stl - e.stl));
      end
    end
    hold = !rst && ov && !ordy;
    ps = s;
    pco = co;
    pof = of;
    if (ov && !ordy) stl++;
    if (iv && ir) begin
      e = model(a, b, cin, sub, sel ? 8 : 16);
      e.cyc = cyc;
      e.stl = stl;
      q.push_back(e);
    end
    if (rst) q.delete();
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input logic m);
    int i;
    a = x; b = y; cin = c; sub = m; iv = 1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ir) break;
    end
    if (i == 50) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 iv = 0;
  endtask

  task automatic single(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c,
                        input logic m, input logic [15:0] es, input logic eco, input logic eof, input int lat);
    int n;
    ordy = 1;
    send(x, y, c, m);
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ov) break;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_sum"}, 32'(s), 32'(es));
    check({tag, "_flags"}, 32'({co, of}), 32'({eco, eof}));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    ordy = 1;
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1 check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] corner [5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
    return ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
  endfunction

  task automatic random_run(input int n);
    bit done = 0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk);
        #1 ordy = ($urandom_range(0, 3) != 0);
      end
    join
    drain();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_state16", 32'({ov16, co16, of16, s16}), 32'd0);
    check("rst_state8", 32'({ov8, co8, of8, s8}), 32'd0);
    rst = 0;
    single("add_carry8", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 4);
    single("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 4);
    single("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 4);
    single("sub_borrow", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 4);
    single("sub_ovf", 16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1, 4);
    fork
      for (int i = 0; i < 8; i++) send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
      begin
        repeat (5) @(posedge clk);
        #1 ordy = 0;
        repeat (3) @(posedge clk);
        #1 ordy = 1;
      end
    join
    drain();
    for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 16'h0101, 0, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    check("rst_flush_valid", 32'(ov16), 32'd0);
    check("rst_flush_sum", 32'(s16), 32'd0);
    single("post_rst", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 4);
    random_run(1000);
    sel = 1;
    single("w8_cin", 16'h00FF, 16'h0000, 1, 0, 16'h0000, 1, 0, 1);
    single("w8_ovf", 16'h007F, 16'h0001, 0, 0, 16'h0080, 0, 1, 1);
    random_run(1000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
